// File: rtl/result_wb.sv
// Writeback engine: drains result words from the transposition unit into SP BRAM
// using the tiled layout, optionally adding the existing BRAM content lane-wise first.
module result_wb #(
    parameter int DATA_W       = 64,
    parameter int LANE_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int ROW_STRIDE   = 128,
    parameter int BLOCK_STRIDE = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       num_words,
    input  logic              accum_en,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              rd_en,
    output logic [31:0]       rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_cnt
);

    localparam int LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_base;
    logic [15:0]        r_num;
    logic [15:0]        r_word_cnt;
    logic               r_accum;

    // Delay line aligning each word and its address with the BRAM read data.
    logic [RD_LAT-1:0]  r_pipe_vld;
    logic [DATA_W-1:0]  r_pipe_data [RD_LAT];
    logic [31:0]        r_pipe_addr [RD_LAT];

    logic               r_wr_en;
    logic [31:0]        r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;

    logic               w_accept;
    logic [31:0]        w_addr;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_wr_data;

    assign res_ready = (r_state == S_DRAIN) && (r_word_cnt < r_num);
    assign w_accept  = res_valid && res_ready;

    // Word k lands at row k[1:0] of tile k>>2.
    assign w_addr = r_base
                  + (32'(r_word_cnt >> 2) * 32'(BLOCK_STRIDE))
                  + (32'(r_word_cnt[1:0]) * 32'(ROW_STRIDE));

    assign rd_en   = w_accept && r_accum;
    assign rd_addr = rd_en ? w_addr : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_sum[gi*LANE_W +: LANE_W] = r_pipe_data[RD_LAT-1][gi*LANE_W +: LANE_W]
                                              + rd_data[gi*LANE_W +: LANE_W];
        end
    endgenerate

    assign w_wr_data = r_accum ? w_sum : r_pipe_data[RD_LAT-1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_words != 16'd0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (w_accept && (r_word_cnt + 16'd1 == r_num)) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The output register may still hold the last write; done follows it.
                if (r_pipe_vld == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= 32'd0;
            r_num      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_accum    <= 1'b0;
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_data[i] <= '0;
                r_pipe_addr[i] <= 32'd0;
            end
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && start) begin
                r_base     <= base_addr;
                r_num      <= num_words;
                r_accum    <= accum_en;
                r_word_cnt <= 16'd0;
            end else if (w_accept) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end

            r_pipe_vld[0]  <= w_accept;
            r_pipe_data[0] <= res_data;
            r_pipe_addr[0] <= w_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end

            r_wr_en <= r_pipe_vld[RD_LAT-1];
            if (r_pipe_vld[RD_LAT-1]) begin
                r_wr_addr <= r_pipe_addr[RD_LAT-1];
                r_wr_data <= w_wr_data;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_result_wb.sv
// Directed bench for result_wb: scoreboard of expected writes filled at acceptance,
// drained by a write monitor; BRAM modelled as an associative array with 1-cycle read.
module tb_result_wb;

    localparam int RD_LAT = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        accum_en;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ready;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;

    result_wb #(
        .DATA_W(64), .LANE_W(16), .RD_LAT(RD_LAT), .ROW_STRIDE(128), .BLOCK_STRIDE(512)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .accum_en(accum_en), .res_valid(res_valid),
        .res_data(res_data), .res_ready(res_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        int          c;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rd_cnt = 0;
    logic [31:0] cur_base;
    logic        cur_accum;
    int          k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem.exists(rd_addr) ? mem[rd_addr] : 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [31:0] b, input int idx);
        return b + 32'((idx / 4) * 512) + 32'((idx % 4) * 128);
    endfunction

    function automatic logic [63:0] lane_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic [15:0] s;
        for (int l = 0; l < 4; l++) begin
            s = x[l*16 +: 16] + y[l*16 +: 16];
            r[l*16 +: 16] = s;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.a));
                chk("wr_data", wr_data, e.d);
                chk("wr_cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_writes", 64'(sb.size()), 64'd0);
        end
        if (rd_en) rd_cnt++;
    end

    task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic acc);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        accum_en  = acc;
        cur_base  = b;
        cur_accum = acc;
        k         = 0;
        done_cnt  = 0;
        rd_cnt    = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("cnt_after_start", 64'(word_cnt), 64'd0);
    endtask

    // Presents d until accepted; leaves res_valid high so calls can run back-to-back.
    task automatic send(input logic [63:0] d);
        bit ok;
        logic [31:0] ea;
        exp_t e;
        ok = 0;
        res_valid = 1'b1;
        res_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (res_ready) begin
                ok = 1;
                ea = addr_of(cur_base, k);
                chk("rd_en", 64'(rd_en), 64'(cur_accum));
                chk("rd_addr", 64'(rd_addr), cur_accum ? 64'(ea) : 64'd0);
                e.a = ea;
                e.d = cur_accum ? lane_add(d, mem.exists(ea) ? mem[ea] : 64'd0) : d;
                e.c = cyc + RD_LAT + 1;
                sb.push_back(e);
                k++;
            end
            @(posedge clk); #1;
        end
        chk("accept_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            chk("busy_until_done", 64'(busy), 64'd1);
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("word_cnt_final", 64'(word_cnt), 64'(n));
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int zs;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; accum_en = 1'b0;
        res_valid = 1'b0; res_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_ready", 64'(res_ready), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain write, 4 words back-to-back.
        do_start(32'h1000, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(64'h0001_0002_0003_0004 + 64'(i));
        res_valid = 1'b0;
        wait_done(4);
        chk("plain_no_rd", 64'(rd_cnt), 64'd0);
        $display("job plain base=1000 n=4 checks=%0d errors=%0d", checks, errors);

        // Accumulate with per-lane wrap.
        mem[addr_of(32'h2000, 0)] = 64'hFFFF_0001_8000_0000;
        for (int i = 1; i < 4; i++) mem[addr_of(32'h2000, i)] = {$urandom, $urandom};
        do_start(32'h2000, 16'd4, 1'b1);
        send(64'h0001_FFFF_8000_1234);
        for (int i = 1; i < 4; i++) send({$urandom, $urandom});
        res_valid = 1'b0;
        wait_done(4);
        chk("accum_rd_count", 64'(rd_cnt), 64'd4);
        $display("job accum base=2000 n=4 checks=%0d errors=%0d", checks, errors);

        // 8 words with a bubble after each one, spanning two tiles.
        for (int i = 0; i < 8; i++) mem[addr_of(32'h3000, i)] = {$urandom, $urandom};
        do_start(32'h3000, 16'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom});
            res_valid = 1'b0;
            if (i == 7) begin
                chk("ready_drop", 64'(res_ready), 64'd0);
                chk("cnt_eight", 64'(word_cnt), 64'd8);
            end
            @(posedge clk); #1;
        end
        wait_done(8);
        $display("job bubbles base=3000 n=8 checks=%0d errors=%0d", checks, errors);

        // Empty job.
        zs = cyc;
        do_start(32'h3800, 16'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_done_once", 64'(done_cnt), 64'd1);
        chk("zero_done_lat", 64'((done_cyc - zs) >= 1 && (done_cyc - zs) <= 2), 64'd1);
        chk("zero_no_rd", 64'(rd_cnt), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        $display("job empty n=0 checks=%0d errors=%0d", checks, errors);

        // Reset with words in flight.
        for (int i = 0; i < 4; i++) mem[addr_of(32'h4000, i)] = {$urandom, $urandom};
        do_start(32'h4000, 16'd4, 1'b1);
        send(64'h1111_2222_3333_4444);
        res_data = 64'h5555_6666_7777_8888;
        @(negedge clk);
        chk("abort_ready", 64'(res_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        res_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_rd_en", 64'(rd_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready_off", 64'(res_ready), 64'd0);
        chk("abort_cnt", 64'(word_cnt), 64'd0);
        @(posedge clk); #1;
        chk("abort_wr_en2", 64'(wr_en), 64'd0);
        chk("abort_sb", 64'(sb.size()), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("job abort base=4000 checks=%0d errors=%0d", checks, errors);

        // Normal job after abort.
        do_start(32'h5000, 16'd3, 1'b0);
        for (int i = 0; i < 3; i++) send(64'hA5A5_0000_0000_0000 + 64'(i));
        res_valid = 1'b0;
        wait_done(3);
        $display("job recover base=5000 n=3 checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
